// File: rtl/ofdm_sym_sched_pkg.sv
// Shared types for the 802.11a TX frame path: FSM encoding, frame constants, sample type.
// Used by the symbol scheduler and by the downstream pilot-insertion and IFFT-feed blocks.
package ofdm_sym_sched_pkg;

  localparam int DW_DEF      = 32;
  localparam int NSC_DEF     = 48;
  localparam int PIL_MOD_DEF = 127;
  localparam int NSYM_W_DEF  = 12;

  typedef logic [DW_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SIG,
    ST_DATA,
    ST_DRAIN
  } state_t;

  // Modular increment of the pilot-polarity index without a divider.
  function automatic logic [6:0] pil_next(input logic [6:0] idx, input int modv);
    return ({25'd0, idx} == 32'(modv - 1)) ? 7'd0 : idx + 7'd1;
  endfunction

endpackage

// File: rtl/ofdm_sym_sched_if.sv
// Wishbone-style bundle: SIGNAL and DATA source ports in, tagged sample stream out.
// The scheduler uses the slave modport; the requesters and pilot insertion use master.
interface ofdm_sym_sched_if #(
  parameter int DW     = 32,
  parameter int NSYM_W = 12
);
  logic [DW-1:0]     SIG_DAT_I;
  logic              SIG_STB_I;
  logic              SIG_CYC_I;
  logic              SIG_ACK_O;
  logic [DW-1:0]     DAT_DAT_I;
  logic              DAT_STB_I;
  logic              DAT_CYC_I;
  logic              DAT_ACK_O;
  logic [NSYM_W-1:0] NSYM_I;
  logic [DW-1:0]     DAT_O;
  logic              WE_O;
  logic              STB_O;
  logic              CYC_O;
  logic              ACK_I;
  logic              SOS_O;
  logic [6:0]        SYM_IDX_O;
  logic              ERR_O;

  modport slave (
    input  SIG_DAT_I, SIG_STB_I, SIG_CYC_I, DAT_DAT_I, DAT_STB_I, DAT_CYC_I, NSYM_I, ACK_I,
    output SIG_ACK_O, DAT_ACK_O, DAT_O, WE_O, STB_O, CYC_O, SOS_O, SYM_IDX_O, ERR_O
  );

  modport master (
    output SIG_DAT_I, SIG_STB_I, SIG_CYC_I, DAT_DAT_I, DAT_STB_I, DAT_CYC_I, NSYM_I, ACK_I,
    input  SIG_ACK_O, DAT_ACK_O, DAT_O, WE_O, STB_O, CYC_O, SOS_O, SYM_IDX_O, ERR_O
  );
endinterface

// File: rtl/ofdm_out_reg.sv
// One-entry output register; load-to-output latency 1 cycle, full throughput.
// Accepts a new word when empty or when the held word is leaving (free = ~vld | rdy).
module ofdm_out_reg #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         free,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  assign free = ~out_vld | out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (free) begin
      out_vld <= in_vld;
      if (in_vld) out_dat <= in_dat;
    end
  end

endmodule

// File: rtl/ofdm_sym_sched.sv
// Frame scheduler: one SIGNAL symbol then NSYM DATA symbols, tagged with SOS and pilot index.
// Accepted samples appear one cycle later; upstream ACK is withheld while the output register is full.
module ofdm_sym_sched
  import ofdm_sym_sched_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int NSC     = NSC_DEF,
  parameter int NSYM_W  = NSYM_W_DEF,
  parameter int PIL_MOD = PIL_MOD_DEF
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  ofdm_sym_sched_if.slave bus
);

  localparam int SW = $clog2(NSC);
  localparam int PW = DW + 1 + 7;

  state_t            state;
  logic [SW-1:0]     samp_cnt;
  logic [NSYM_W-1:0] sym_cnt;
  logic [NSYM_W-1:0] nsym_r;
  logic [6:0]        sym_idx;
  logic              src_up;
  logic              cyc_r;
  logic              err_r;

  logic              free;
  logic              sig_acc;
  logic              dat_acc;
  logic              src_cyc;
  logic              abort;
  logic              samp_last;
  logic              sym_last;
  logic              out_vld;
  logic [PW-1:0]     out_pay;
  logic [PW-1:0]     in_pay;

  assign sig_acc   = (state == ST_SIG)  & bus.SIG_CYC_I & bus.SIG_STB_I & free;
  assign dat_acc   = (state == ST_DATA) & bus.DAT_CYC_I & bus.DAT_STB_I & free;
  assign src_cyc   = (state == ST_SIG) ? bus.SIG_CYC_I : bus.DAT_CYC_I;
  // src_up keeps a DATA source that has not raised CYC yet from counting as an abort.
  assign abort     = ((state == ST_SIG) | (state == ST_DATA)) & src_up & ~src_cyc;
  assign samp_last = (samp_cnt == SW'(NSC - 1));
  assign sym_last  = (sym_cnt == nsym_r - NSYM_W'(1));
  assign in_pay    = {(sig_acc ? bus.SIG_DAT_I : bus.DAT_DAT_I), (samp_cnt == '0), sym_idx};

  ofdm_out_reg #(.W(PW)) u_out_reg (
    .clk     (CLK_I),
    .rst_n   (RST_I),
    .in_vld  (sig_acc | dat_acc),
    .in_dat  (in_pay),
    .free    (free),
    .out_vld (out_vld),
    .out_dat (out_pay),
    .out_rdy (bus.ACK_I)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state    <= ST_IDLE;
      samp_cnt <= '0;
      sym_cnt  <= '0;
      nsym_r   <= '0;
      sym_idx  <= '0;
      src_up   <= 1'b0;
      cyc_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state)
        ST_IDLE: if (bus.SIG_CYC_I & bus.SIG_STB_I) begin
          nsym_r   <= bus.NSYM_I;
          cyc_r    <= 1'b1;
          samp_cnt <= '0;
          sym_cnt  <= '0;
          sym_idx  <= '0;
          src_up   <= 1'b1;
          state    <= ST_SIG;
        end
        ST_SIG: begin
          if (abort) begin
            err_r <= 1'b1;
            state <= ST_DRAIN;
          end else if (sig_acc) begin
            if (samp_last) begin
              samp_cnt <= '0;
              sym_idx  <= pil_next(sym_idx, PIL_MOD);
              src_up   <= 1'b0;
              state    <= (nsym_r != '0) ? ST_DATA : ST_DRAIN;
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
        end
        ST_DATA: begin
          src_up <= src_up | bus.DAT_CYC_I;
          if (abort) begin
            err_r <= 1'b1;
            state <= ST_DRAIN;
          end else if (dat_acc) begin
            if (samp_last) begin
              samp_cnt <= '0;
              sym_cnt  <= sym_cnt + NSYM_W'(1);
              sym_idx  <= pil_next(sym_idx, PIL_MOD);
              if (sym_last) state <= ST_DRAIN;
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
        end
        ST_DRAIN: if (free) begin
          cyc_r    <= 1'b0;
          samp_cnt <= '0;
          sym_cnt  <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SIG_ACK_O = sig_acc;
  assign bus.DAT_ACK_O = dat_acc;
  assign bus.DAT_O     = out_pay[PW-1 -: DW];
  assign bus.SOS_O     = out_pay[7];
  assign bus.SYM_IDX_O = out_pay[6:0];
  assign bus.STB_O     = out_vld;
  assign bus.WE_O      = out_vld;
  assign bus.CYC_O     = cyc_r;
  assign bus.ERR_O     = err_r;

endmodule

// File: doc/ofdm_sym_sched.md
Name: ofdm_sym_sched

Overview:
- Frame scheduler in the 802.11a TX chain, directly ahead of the pilot-insertion stage.
- Shares that stage's single Wishbone-style input between two requesters: the SIGNAL-field mapper and the DATA-field mapper.
- Enforces the frame order: one SIGNAL symbol, then NSYM_I DATA symbols, each of NSC samples.
- Tags every output sample with a start-of-symbol flag and the pilot-polarity index, so pilot insertion needs no symbol counting of its own.

Parameters:
DW, 32, sample width (16-bit I / 16-bit Q packed)
NSC, 48, data subcarriers per OFDM symbol
NSYM_W, 12, width of the data-symbol count
PIL_MOD, 127, pilot polarity sequence length (index wraps at PIL_MOD-1)

Ports:
CLK_I  in  1  system clock
RST_I  in  1  asynchronous, active-low reset
SIG_DAT_I  in  DW  SIGNAL-field sample
SIG_STB_I  in  1  SIGNAL strobe
SIG_CYC_I  in  1  SIGNAL cycle
SIG_ACK_O  out  1  SIGNAL sample accepted
DAT_DAT_I  in  DW  DATA-field sample
DAT_STB_I  in  1  DATA strobe
DAT_CYC_I  in  1  DATA cycle
DAT_ACK_O  out  1  DATA sample accepted
NSYM_I  in  NSYM_W  DATA symbols in frame; sampled at frame start
DAT_O  out  DW  sample to pilot insertion
WE_O  out  1  write qualifier, equals STB_O
STB_O  out  1  output sample valid
CYC_O  out  1  frame in progress
ACK_I  in  1  downstream accepted
SOS_O  out  1  start of symbol, aligned with DAT_O
SYM_IDX_O  out  7  pilot polarity index, aligned with DAT_O
ERR_O  out  1  one-cycle pulse on upstream abort

Behaviour:
- Reset (RST_I=0, async): every output is 0; FSM state=IDLE; all counters are 0.
- Output stage: a one-entry register holding DAT_O/SOS_O/SYM_IDX_O/STB_O.
  - free = ~STB_O | ACK_I.
  - A downstream transfer occurs when STB_O & ACK_I.
- Upstream accept:
  - Combinational ACK_O to the granted source only: ACK = src_CYC & src_STB & free & state accepts that source.
  - The non-granted ACK_O stays 0.
- Latency: an accepted sample appears on DAT_O on the next cycle. STB_O falls after a transfer unless a new sample is accepted in the same cycle (full throughput, 1 sample/clk).
- States:
  - IDLE: CYC_O=0. On SIG_CYC_I&SIG_STB_I, latch NSYM_I into nsym_r, set CYC_O=1, go to SIG. DAT requests are ignored (DAT_ACK_O=0).
  - SIG:
    - Accept from the SIG port only; samp_cnt counts 0..NSC-1.
    - The first sample carries SOS=1, SYM_IDX=0.
    - On the NSC-th accept: go to DATA if nsym_r!=0, else to DRAIN.
  - DATA:
    - Accept from the DAT port only.
    - sym_cnt counts 0..nsym_r-1.
    - samp_cnt wraps NSC-1 -> 0, and sym_cnt increments on the wrap.
    - SOS=1 on samp_cnt==0. SYM_IDX = (sym_cnt+1) mod PIL_MOD, i.e. the first DATA symbol has index 1 and 126 wraps to 0.
    - On the last sample of the last symbol, go to DRAIN.
  - DRAIN: no accepts. When the output register is empty or transferring (free), set CYC_O=0 and go to IDLE.
- Abort:
  - If the granted source deasserts CYC during SIG or DATA before the final sample, pulse ERR_O for 1 cycle and go to DRAIN.
  - The partial symbol already registered is still delivered.
- Simultaneous events:
  - SIG and DAT requesting together in IDLE: SIG wins.
  - Accept and downstream transfer in the same cycle: both occur, no bubble.
- NSYM_I changes mid-frame are ignored until the next IDLE->SIG transition.
- Counter widths:
  - samp_cnt: ceil(log2(NSC)) bits.
  - sym_cnt: NSYM_W bits.
  - Pilot index: 7-bit modular counter (no divider).
- Reset asserted mid-frame: immediate return to reset values; a partially delivered frame is discarded.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, SIG, DATA, DRAIN).
  - NSC=48 and PIL_MOD=127 constants.
  - The DW sample type, for reuse by the pilot-insertion and IFFT-feed blocks.
- Natural sub-module: ofdm_out_reg, the one-entry output register with free/transfer logic, reusable by other stages.

Test Plan:
1. Reset, then SIG sends 48 samples 1..48, DAT sends 2x48 samples, NSYM_I=2, ACK_I=1 -> 144 consecutive STB_O cycles. SOS_O at samples 1, 49 and 97 with SYM_IDX_O 0, 1, 2. CYC_O drops 1 cycle after the last transfer.
2. Same frame, ACK_I low for 14 cycles after the first STB_O and low 7 cycles around sample 80 -> no sample lost or duplicated; DAT_O order is 1..144; ACK_O is held 0 while the register is full.
3. NSYM_I=0 -> only 48 SIG samples output; DAT_ACK_O never asserted; FSM returns to IDLE.
4. NSYM_I=130, DAT source always valid -> SYM_IDX_O for the first DATA symbol is 1. It wraps 126->0 at DATA symbol 127 and reads 3 at the last symbol (130 mod 127).
5. DAT_CYC_I dropped after 20 samples of DATA symbol 0 -> ERR_O single pulse; 48+20 samples delivered; CYC_O falls; next SIG request starts a new frame with SYM_IDX_O=0.
6. RST_I pulsed low mid-DATA -> all outputs 0 asynchronously; after release, DAT requests are ignored until a SIG request arrives.
